uart_tx: RTL

//  UART transmitter, companion to the UART receiver top on the same link.

---
 rtl/uart_tx.sv | 133 +++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// UART transmitter: one word per Data_Valid handshake, sent as start bit, LSB-first data,
// optional parity and one stop bit, each held for Prescale clock cycles.
module uart_tx #(
  parameter int out_width = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [out_width-1:0] P_DATA,
  input  logic                 Data_Valid,
  input  logic                 Parity_EN,
  input  logic                 Parity_type,
  input  logic [3:0]           Prescale,
  output logic                 TX_OUT,
  output logic                 Busy
);

  // state  | meaning
  // IDLE   | line high, waiting for Data_Valid
  // START  | start bit (low)
  // DATA   | data bits, LSB first, from the shift register
  // PARITY | parity of the latched word
  // STOP   | stop bit (high); Busy drops at its final edge

  localparam int IW = (out_width > 1) ? $clog2(out_width) : 1;
  localparam logic [IW-1:0] LAST_BIT = IW'(out_width - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state, state_nxt;
  logic [3:0]           cyc, cyc_nxt;
  logic [3:0]           per, per_nxt;
  logic [IW-1:0]        idx, idx_nxt;
  logic [out_width-1:0] shreg, shreg_nxt;
  logic                 par_en, par_en_nxt;
  logic                 par_bit, par_bit_nxt;
  logic                 tx_nxt, busy_nxt;
  logic                 wrap;

  // per is forced non-zero at accept, so per-1 is a valid last-cycle index
  assign wrap = (cyc == per - 4'd1);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state   <= IDLE;
      cyc     <= '0;
      per     <= '0;
      idx     <= '0;
      shreg   <= '0;
      par_en  <= 1'b0;
      par_bit <= 1'b0;
      TX_OUT  <= 1'b1;
      Busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cyc     <= cyc_nxt;
      per     <= per_nxt;
      idx     <= idx_nxt;
      shreg   <= shreg_nxt;
      par_en  <= par_en_nxt;
      par_bit <= par_bit_nxt;
      TX_OUT  <= tx_nxt;
      Busy    <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cyc_nxt     = cyc;
    per_nxt     = per;
    idx_nxt     = idx;
    shreg_nxt   = shreg;
    par_en_nxt  = par_en;
    par_bit_nxt = par_bit;
    tx_nxt      = TX_OUT;
    busy_nxt    = Busy;

    if (state == IDLE) begin
      tx_nxt   = 1'b1;
      busy_nxt = 1'b0;
      if (Data_Valid) begin
        state_nxt   = START;
        shreg_nxt   = P_DATA;
        par_en_nxt  = Parity_EN;
        par_bit_nxt = (^P_DATA) ^ Parity_type;
        per_nxt     = (Prescale == 4'd0) ? 4'd1 : Prescale;
        cyc_nxt     = '0;
        idx_nxt     = '0;
        tx_nxt      = 1'b0;
        busy_nxt    = 1'b1;
      end
    end else if (!wrap) begin
      cyc_nxt = cyc + 4'd1;
    end else begin
      cyc_nxt = '0;
      case (state)
        START: begin
          state_nxt = DATA;
          tx_nxt    = shreg[0];
        end
        DATA: begin
          if (idx == LAST_BIT) begin
            if (par_en) begin
              state_nxt = PARITY;
              tx_nxt    = par_bit;
            end else begin
              state_nxt = STOP;
              tx_nxt    = 1'b1;
            end
          end else begin
            idx_nxt   = idx + 1'b1;
            shreg_nxt = shreg >> 1;
            tx_nxt    = shreg[1];
          end
        end
        PARITY: begin
          state_nxt = STOP;
          tx_nxt    = 1'b1;
        end
        STOP: begin
          state_nxt = IDLE;
          tx_nxt    = 1'b1;
          busy_nxt  = 1'b0;
        end
        default: begin
          state_nxt = IDLE;
          tx_nxt    = 1'b1;
          busy_nxt  = 1'b0;
        end
      endcase
    end
  end

endmodule
